// File: rtl/fake_cd_pkg.sv
// Shared constants, FSM state type and the INQUIRY response ROM for the fake CD-ROM target.
package fake_cd_pkg;

    localparam logic [7:0] OP_TUR       = 8'h00;
    localparam logic [7:0] OP_REQ_SENSE = 8'h03;
    localparam logic [7:0] OP_INQUIRY   = 8'h12;
    localparam logic [7:0] OP_READ6     = 8'h08;
    localparam logic [7:0] OP_READ10    = 8'h28;

    localparam logic [7:0] ST_GOOD  = 8'h00;
    localparam logic [7:0] ST_CHECK = 8'h02;

    localparam logic [7:0] SENSE_LEN   = 8'd18;
    localparam logic [7:0] INQUIRY_LEN = 8'd36;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        DATA,
        STAT
    } state_t;

    // Vendor/product identification, occupies INQUIRY bytes 8..35
    localparam logic [8*28-1:0] INQ_IDENT = "NEC     CD-ROM DRIVE:FX     ";

    function automatic logic [7:0] inquiry_byte(input logic [23:0] idx);
        logic [7:0] b;
        logic [4:0] k;
        k = 5'(idx - 24'd8);
        case (idx)
            24'd0:   b = 8'h05;
            24'd1:   b = 8'h80;
            24'd2:   b = 8'h02;
            24'd3:   b = 8'h02;
            24'd4:   b = 8'h1F;
            default: begin
                if (idx >= 24'd8 && idx <= 24'd35)
                    b = INQ_IDENT[8*(27 - int'(k)) +: 8];
                else
                    b = 8'h00;
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fake_cd_pattern.sv
// Combinational data-in byte generator for the current response position.
module fake_cd_pattern
    import fake_cd_pkg::*;
(
    input  logic [7:0]  opcode,
    input  logic [23:0] byte_idx,
    input  logic [10:0] sec_off,
    input  logic [7:0]  lba_lo,
    output logic [7:0]  data
);

    always_comb begin
        data = 8'h00;
        case (opcode)
            OP_REQ_SENSE: begin
                if (byte_idx == 24'd0)
                    data = 8'h70;
                else if (byte_idx == 24'd7)
                    data = 8'h0A;
            end
            OP_INQUIRY:          data = inquiry_byte(byte_idx);
            OP_READ6, OP_READ10: data = sec_off[7:0] ^ lba_lo ^ {5'd0, sec_off[10:8]};
            default:             data = 8'h00;
        endcase
    end

endmodule

// File: rtl/fake_cd_drive.sv
// Synthetic CD-ROM target: latches a CDB, waits, streams canned data bytes, then reports status.
module fake_cd_drive
    import fake_cd_pkg::*;
#(
    parameter int RESP_DELAY   = 16,
    parameter int BYTE_GAP     = 8,
    parameter int SECTOR_BYTES = 2048
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [95:0] COMMAND,
    input  logic        COMM_SEND,
    output logic        STAT_GET,
    output logic [7:0]  STATUS,
    output logic [7:0]  CD_DATA,
    output logic        CD_WR
);

    logic [7:0]  cdb_byte [12];
    state_t      state_reg;
    logic [7:0]  opcode_reg, status_val_reg, status_reg, cd_data_reg;
    logic [23:0] len_reg, byte_idx_reg;
    logic [15:0] delay_reg, gap_reg, sec_off_reg;
    logic [20:0] lba_reg;
    logic        stat_get_reg, cd_wr_reg;
    logic [7:0]  dec_status, pattern_byte;
    logic [23:0] dec_len;
    logic [20:0] dec_lba;
    logic [15:0] dec_sectors;
    logic        emit;

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_cdb
            assign cdb_byte[gi] = COMMAND[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        dec_status  = ST_GOOD;
        dec_len     = '0;
        dec_lba     = '0;
        dec_sectors = '0;
        case (cdb_byte[0])
            OP_TUR: ;
            OP_REQ_SENSE:
                dec_len = {16'd0, (cdb_byte[4] > SENSE_LEN) ? SENSE_LEN : cdb_byte[4]};
            OP_INQUIRY:
                dec_len = {16'd0, (cdb_byte[4] > INQUIRY_LEN) ? INQUIRY_LEN : cdb_byte[4]};
            OP_READ6: begin
                dec_lba     = {cdb_byte[1][4:0], cdb_byte[2], cdb_byte[3]};
                dec_sectors = (cdb_byte[4] == 8'd0) ? 16'd256 : {8'd0, cdb_byte[4]};
                dec_len     = 24'(dec_sectors) * 24'(SECTOR_BYTES);
            end
            OP_READ10: begin
                dec_lba     = {cdb_byte[3][4:0], cdb_byte[4], cdb_byte[5]};
                dec_sectors = {cdb_byte[7], cdb_byte[8]};
                dec_len     = 24'(dec_sectors) * 24'(SECTOR_BYTES);
            end
            default: dec_status = ST_CHECK;
        endcase
    end

    // A byte goes out on the first response clock and then every BYTE_GAP clocks
    always_comb begin
        emit = ((state_reg == DELAY) && (delay_reg == 16'd0) && (len_reg != 24'd0)) ||
               ((state_reg == DATA) && (gap_reg == 16'd0) && (byte_idx_reg != len_reg));
    end

    fake_cd_pattern u_pattern (
        .opcode   (opcode_reg),
        .byte_idx (byte_idx_reg),
        .sec_off  (sec_off_reg[10:0]),
        .lba_lo   (lba_reg[7:0]),
        .data     (pattern_byte)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_reg      <= IDLE;
            opcode_reg     <= '0;
            status_val_reg <= '0;
            status_reg     <= '0;
            cd_data_reg    <= '0;
            len_reg        <= '0;
            byte_idx_reg   <= '0;
            delay_reg      <= '0;
            gap_reg        <= '0;
            sec_off_reg    <= '0;
            lba_reg        <= '0;
            stat_get_reg   <= 1'b0;
            cd_wr_reg      <= 1'b0;
        end else begin
            cd_wr_reg    <= 1'b0;
            stat_get_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (COMM_SEND) begin
                        opcode_reg     <= cdb_byte[0];
                        status_val_reg <= dec_status;
                        len_reg        <= dec_len;
                        lba_reg        <= dec_lba;
                        byte_idx_reg   <= '0;
                        sec_off_reg    <= '0;
                        delay_reg      <= 16'(RESP_DELAY);
                        state_reg      <= DELAY;
                    end
                end
                DELAY: begin
                    if (delay_reg != 16'd0) begin
                        delay_reg <= delay_reg - 16'd1;
                    end else if (len_reg != 24'd0) begin
                        state_reg <= DATA;
                    end else begin
                        status_reg   <= status_val_reg;
                        stat_get_reg <= 1'b1;
                        state_reg    <= STAT;
                    end
                end
                DATA: begin
                    if (byte_idx_reg == len_reg) begin
                        status_reg   <= status_val_reg;
                        stat_get_reg <= 1'b1;
                        state_reg    <= STAT;
                    end else if (gap_reg != 16'd0) begin
                        gap_reg <= gap_reg - 16'd1;
                    end
                end
                STAT:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            if (emit) begin
                cd_wr_reg    <= 1'b1;
                cd_data_reg  <= pattern_byte;
                byte_idx_reg <= byte_idx_reg + 24'd1;
                gap_reg      <= 16'(BYTE_GAP - 1);
                // Sector LBA advances modulo 2^21 by natural wrap of lba_reg
                if (sec_off_reg == 16'(SECTOR_BYTES - 1)) begin
                    sec_off_reg <= '0;
                    lba_reg     <= lba_reg + 21'd1;
                end else begin
                    sec_off_reg <= sec_off_reg + 16'd1;
                end
            end
        end
    end

    assign STAT_GET = stat_get_reg;
    assign STATUS   = status_reg;
    assign CD_DATA  = cd_data_reg;
    assign CD_WR    = cd_wr_reg;

endmodule

// File: tb/tb_fake_cd_drive.sv
// Randomized and directed bench for fake_cd_drive against a byte-list reference model.
module tb_fake_cd_drive;

    localparam int RESP_DELAY   = 16;
    localparam int BYTE_GAP     = 3;
    localparam int SECTOR_BYTES = 2048;

    logic        clk = 1'b0;
    logic        res;
    logic [95:0] command;
    logic        comm_send;
    logic        stat_get;
    logic [7:0]  status;
    logic [7:0]  cd_data;
    logic        cd_wr;

    always #5 clk = ~clk;

    fake_cd_drive #(
        .RESP_DELAY   (RESP_DELAY),
        .BYTE_GAP     (BYTE_GAP),
        .SECTOR_BYTES (SECTOR_BYTES)
    ) dut (
        .CLK       (clk),
        .RES       (res),
        .COMMAND   (command),
        .COMM_SEND (comm_send),
        .STAT_GET  (stat_get),
        .STATUS    (status),
        .CD_DATA   (cd_data),
        .CD_WR     (cd_wr)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_status;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] mk(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                       input logic [7:0] b7, input logic [7:0] b8);
        return {24'h0, b8, b7, 8'h00, b5, b4, b3, b2, b1, op};
    endfunction

    // Reference model: the full expected byte list and status for one CDB
    task automatic build_expect(input logic [95:0] c);
        logic [7:0] b [12];
        logic [7:0] hdr [5] = '{8'h05, 8'h80, 8'h02, 8'h02, 8'h1F};
        string      ident = "NEC     CD-ROM DRIVE:FX     ";
        int         len, lba, n, sec;
        for (int i = 0; i < 12; i++) b[i] = c[8*i +: 8];
        exp_q.delete();
        exp_status = 8'h00;
        n = 0;
        lba = 0;
        case (b[0])
            8'h00: ;
            8'h03: begin
                len = (int'(b[4]) < 18) ? int'(b[4]) : 18;
                for (int i = 0; i < len; i++)
                    exp_q.push_back((i == 0) ? 8'h70 : ((i == 7) ? 8'h0A : 8'h00));
            end
            8'h12: begin
                len = (int'(b[4]) < 36) ? int'(b[4]) : 36;
                for (int i = 0; i < len; i++) begin
                    if (i < 5)       exp_q.push_back(hdr[i]);
                    else if (i >= 8) exp_q.push_back(8'(ident[i-8]));
                    else             exp_q.push_back(8'h00);
                end
            end
            8'h08: begin
                lba = int'({b[1][4:0], b[2], b[3]});
                n   = (b[4] == 8'd0) ? 256 : int'(b[4]);
            end
            8'h28: begin
                lba = int'({b[2], b[3], b[4], b[5]} & 32'h001F_FFFF);
                n   = int'({b[7], b[8]});
            end
            default: exp_status = 8'h02;
        endcase
        for (int s = 0; s < n; s++) begin
            sec = (lba + s) % (1 << 21);
            for (int o = 0; o < SECTOR_BYTES; o++)
                exp_q.push_back(8'((o % 256) ^ (sec % 256) ^ ((o / 256) % 8)));
        end
    endtask

    task automatic run_cmd(input string name, input logic [95:0] c, input int inject_at, input logic [95:0] c2);
        int         t = 0, idx = 0, last_t = 0, first_t = -1, stat_t = -1, budget, strays = 0;
        logic [7:0] last_d = 8'h00;
        build_expect(c);
        budget = RESP_DELAY + 10 + exp_q.size() * BYTE_GAP;
        @(negedge clk);
        command   = c;
        comm_send = 1'b1;
        @(negedge clk);
        comm_send = 1'b0;
        while (stat_t < 0 && t < budget) begin
            @(negedge clk);
            t++;
            if (t == inject_at) begin
                command   = c2;
                comm_send = 1'b1;
            end else begin
                comm_send = 1'b0;
            end
            if (cd_wr) begin
                if (idx == 0) first_t = t;
                else check({name, " gap"}, 32'(t - last_t), 32'(BYTE_GAP));
                if (idx < exp_q.size())
                    check($sformatf("%s byte%0d", name, idx), 32'(cd_data), 32'(exp_q[idx]));
                last_t = t;
                last_d = cd_data;
                idx++;
            end else if (idx > 0) begin
                check({name, " data hold"}, 32'(cd_data), 32'(last_d));
            end
            if (stat_get) stat_t = t;
        end
        comm_send = 1'b0;
        check({name, " stat_get seen"}, 32'(stat_t >= 0), 32'd1);
        check({name, " byte count"}, 32'(idx), 32'(exp_q.size()));
        if (stat_t >= 0) begin
            check({name, " status"}, 32'(status), 32'(exp_status));
            if (exp_q.size() == 0)
                check({name, " stat latency ok"}, 32'(stat_t >= RESP_DELAY && stat_t <= RESP_DELAY + 2), 32'd1);
            else if (idx > 0) begin
                check({name, " first byte latency ok"}, 32'(first_t >= RESP_DELAY && first_t <= RESP_DELAY + 2), 32'd1);
                check({name, " stat after last byte"}, 32'(stat_t - last_t), 32'd1);
            end
        end
        repeat (RESP_DELAY + 6) begin
            @(negedge clk);
            if (cd_wr || stat_get) strays++;
        end
        check({name, " quiet after stat"}, 32'(strays), 32'd0);
        check({name, " status hold"}, 32'(status), 32'(exp_status));
        $display("cmd %-12s op=%02h bytes=%0d status=%02h", name, c[7:0], idx, status);
    endtask

    task automatic abort_read();
        int strays = 0;
        @(negedge clk);
        command   = mk(8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01);
        comm_send = 1'b1;
        @(negedge clk);
        comm_send = 1'b0;
        repeat (RESP_DELAY + 1 + 10 * BYTE_GAP) @(negedge clk);
        check("abort strobe before reset", 32'(cd_wr), 32'd1);
        #2 res = 1'b1;
        #1;
        check("abort cd_wr", 32'(cd_wr), 32'd0);
        check("abort cd_data", 32'(cd_data), 32'd0);
        check("abort status", 32'(status), 32'd0);
        check("abort stat_get", 32'(stat_get), 32'd0);
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        repeat (RESP_DELAY + 40) begin
            @(negedge clk);
            if (cd_wr || stat_get) strays++;
        end
        check("abort no strobes after", 32'(strays), 32'd0);
        $display("cmd %-12s op=28 aborted by reset", "abort");
    endtask

    initial begin
        logic [95:0] c;
        int          sel;
        res       = 1'b1;
        comm_send = 1'b0;
        command   = '0;
        repeat (3) @(negedge clk);
        check("reset stat_get", 32'(stat_get), 32'd0);
        check("reset status", 32'(status), 32'd0);
        check("reset cd_data", 32'(cd_data), 32'd0);
        check("reset cd_wr", 32'(cd_wr), 32'd0);
        res = 1'b0;

        run_cmd("tur", '0, -1, '0);
        run_cmd("inquiry36", mk(8'h12, 8'h00, 8'h00, 8'h00, 8'd36, 8'h00, 8'h00, 8'h00), -1, '0);
        run_cmd("read10", mk(8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01), -1, '0);
        run_cmd("bad_op", mk(8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), -1, '0);
        run_cmd("inq_inject", mk(8'h12, 8'h00, 8'h00, 8'h00, 8'd36, 8'h00, 8'h00, 8'h00), 30,
                mk(8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05));
        run_cmd("sense_max", mk(8'h03, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00), -1, '0);
        run_cmd("read6_wrap", mk(8'h08, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00), -1, '0);

        for (int k = 0; k < 6; k++) begin
            c   = {$urandom, $urandom, $urandom};
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: c[7:0] = 8'h00;
                1: begin c[7:0] = 8'h03; c[39:32] = 8'($urandom_range(0, 40)); end
                2: begin c[7:0] = 8'h12; c[39:32] = 8'($urandom_range(0, 63)); end
                3: begin c[7:0] = 8'h08; c[39:32] = 8'd1; end
                4: begin c[7:0] = 8'h28; c[63:56] = 8'd0; c[71:64] = 8'd1; end
                default: begin
                    if (c[7:0] == 8'h00 || c[7:0] == 8'h03 || c[7:0] == 8'h12 ||
                        c[7:0] == 8'h08 || c[7:0] == 8'h28)
                        c[7:0] = 8'h5A;
                end
            endcase
            run_cmd($sformatf("rnd%0d", k), c, -1, '0);
        end

        run_cmd("pre_abort", mk(8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), -1, '0);
        abort_read();
        run_cmd("tur_after", '0, -1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
